// File: rtl/mesh_term_injector_if.sv
// Local request and mesh terminal interface for mesh_term_injector.
// The master side is the packet source plus the mesh terminal; the slave side is the injector.
interface mesh_term_injector_if #(
    parameter int PAKG_SIZE  = 32,
    parameter int FIFO_DEPTH = 16
);
    logic                               push_i;
    logic                               bcst_i;
    logic [3:0]                         dest_row_i;
    logic [3:0]                         dest_col_i;
    logic                               mode_i;
    logic [PAKG_SIZE-18:0]              payload_i;
    logic                               full_o;
    logic                               pndng_o;
    logic [PAKG_SIZE-1:0]               data_out_o;
    logic                               popin_i;
    logic [$clog2(FIFO_DEPTH+1)-1:0]    count_o;
    logic [15:0]                        drop_cnt_o;
    logic [15:0]                        sent_cnt_o;

    modport master (
        output push_i, bcst_i, dest_row_i, dest_col_i, mode_i, payload_i, popin_i,
        input  full_o, pndng_o, data_out_o, count_o, drop_cnt_o, sent_cnt_o
    );

    modport slave (
        input  push_i, bcst_i, dest_row_i, dest_col_i, mode_i, payload_i, popin_i,
        output full_o, pndng_o, data_out_o, count_o, drop_cnt_o, sent_cnt_o
    );
endinterface

// File: rtl/mesh_term_injector.sv
// Terminal-side injection stage: formats and validates local packet requests, buffers them in
// a first-word-fall-through FIFO and offers them to one external mesh terminal port.
module mesh_term_injector #(
    parameter int          ROWS       = 4,
    parameter int          COLUMNS    = 4,
    parameter int          PAKG_SIZE  = 32,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [7:0]  BDCST      = 8'hFF
) (
    input  logic                 clk,
    input  logic                 reset,
    mesh_term_injector_if.slave  bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_C    = CW'(FIFO_DEPTH - 1);
    localparam logic [3:0]    ROW_MAX   = 4'(ROWS);
    localparam logic [3:0]    ROW_EDGE  = 4'(ROWS + 1);
    localparam logic [3:0]    COL_MAX   = 4'(COLUMNS);
    localparam logic [3:0]    COL_EDGE  = 4'(COLUMNS + 1);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2
    } state_t;

    // Terminals sit on the ring just outside the router grid; interior coordinates are routers.
    function automatic logic dest_valid(input logic [3:0] r, input logic [3:0] c);
        logic row_edge;
        logic col_edge;
        logic row_in;
        logic col_in;
        row_edge = (r == 4'd0) || (r == ROW_EDGE);
        col_edge = (c == 4'd0) || (c == COL_EDGE);
        row_in   = (r >= 4'd1) && (r <= ROW_MAX);
        col_in   = (c >= 4'd1) && (c <= COL_MAX);
        return (row_edge && col_in) || (col_edge && row_in);
    endfunction

    logic [PAKG_SIZE-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [CW-1:0]        count_r;
    logic [15:0]          drop_cnt_r;
    logic [15:0]          sent_cnt_r;
    logic [PAKG_SIZE-1:0] data_out_r;
    state_t               state_r;

    logic [PAKG_SIZE-1:0] pkt_s;
    logic                 pop_s;
    logic                 accept_s;
    logic                 reject_s;
    logic [CW-1:0]        count_next_s;
    logic [AW-1:0]        rd_next_s;
    logic [PAKG_SIZE-1:0] head_next_s;
    state_t               state_next_s;
    logic                 pndng_s;
    logic                 full_s;

    // Packet assembly and accept/reject decision for this edge.
    always_comb begin
        pkt_s    = {PAKG_SIZE{1'b0}};
        if (bus.bcst_i) begin
            pkt_s = {BDCST, bus.dest_row_i, bus.dest_col_i, bus.mode_i, bus.payload_i};
        end else begin
            pkt_s = {8'h00, bus.dest_row_i, bus.dest_col_i, bus.mode_i, bus.payload_i};
        end
        pop_s    = bus.popin_i && (count_r != {CW{1'b0}});
        accept_s = bus.push_i && (bus.bcst_i || dest_valid(bus.dest_row_i, bus.dest_col_i))
                   && ((count_r != DEPTH_C) || pop_s);
        reject_s = bus.push_i && !accept_s;
    end

    // Next occupancy and next head; the head is the incoming packet when it lands at the new read slot.
    always_comb begin
        count_next_s = count_r;
        case ({accept_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
        if (pop_s) begin
            rd_next_s = rd_ptr_r + AW'(1);
        end else begin
            rd_next_s = rd_ptr_r;
        end
        if (count_next_s == {CW{1'b0}}) begin
            head_next_s = {PAKG_SIZE{1'b0}};
        end else if (accept_s && (rd_next_s == wr_ptr_r)) begin
            head_next_s = pkt_s;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // Packet storage; contents are meaningless outside the occupied window, so no reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= pkt_s;
        end
    end

    // Pointers, occupancy, statistics and registered head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            drop_cnt_r <= 16'h0000;
            sent_cnt_r <= 16'h0000;
            data_out_r <= {PAKG_SIZE{1'b0}};
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            rd_ptr_r   <= rd_next_s;
            count_r    <= count_next_s;
            data_out_r <= head_next_s;
            if (pop_s) begin
                sent_cnt_r <= sent_cnt_r + 16'd1;
            end
            if (reject_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Occupancy state transitions.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_next_s = ST_ACTIVE;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_ACTIVE: begin
                if (accept_s && !pop_s && (count_r == LAST_C)) begin
                    state_next_s = ST_FULL;
                end else if (pop_s && !accept_s && (count_r == CW'(1))) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_ACTIVE;
                end
            end
            ST_FULL: begin
                if (pop_s && !accept_s) begin
                    state_next_s = ST_ACTIVE;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            default: state_next_s = ST_EMPTY;
        endcase
    end

    // Status flags decoded from the registered state.
    always_comb begin
        pndng_s = 1'b0;
        full_s  = 1'b0;
        case (state_r)
            ST_ACTIVE: pndng_s = 1'b1;
            ST_FULL: begin
                pndng_s = 1'b1;
                full_s  = 1'b1;
            end
            default: begin
                pndng_s = 1'b0;
                full_s  = 1'b0;
            end
        endcase
    end

    assign bus.pndng_o    = pndng_s;
    assign bus.full_o     = full_s;
    assign bus.data_out_o = data_out_r;
    assign bus.count_o    = count_r;
    assign bus.drop_cnt_o = drop_cnt_r;
    assign bus.sent_cnt_o = sent_cnt_r;

endmodule

// File: tb/tb_mesh_term_injector.sv
// Randomised scoreboard bench for mesh_term_injector: a queue-based reference model predicts
// occupancy and statistics, and a negedge monitor checks every packet the mesh consumes.
module tb_mesh_term_injector;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int PS   = 32;
    localparam int DEP  = 16;

    logic clk;
    logic reset;

    mesh_term_injector_if #(.PAKG_SIZE(PS), .FIFO_DEPTH(DEP)) bus ();

    mesh_term_injector #(
        .ROWS(ROWS), .COLUMNS(COLS), .PAKG_SIZE(PS), .FIFO_DEPTH(DEP), .BDCST(8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [PS-1:0] model_q[$];
    logic [PS-1:0] sb_q[$];
    int            exp_drop = 0;
    int            exp_sent = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit dest_ok(input int r, input int c);
        bit row_edge = (r == 0) || (r == ROWS + 1);
        bit col_edge = (c == 0) || (c == COLS + 1);
        bit row_in   = (r >= 1) && (r <= ROWS);
        bit col_in   = (c >= 1) && (c <= COLS);
        return (row_edge && col_in) || (col_edge && row_in);
    endfunction

    function automatic logic [PS-1:0] build_pkt(input logic bc, input logic [3:0] r, input logic [3:0] c,
                                               input logic m, input logic [PS-18:0] pl);
        logic [7:0] top;
        top = bc ? 8'hFF : 8'h00;
        return {top, r, c, m, pl};
    endfunction

    // Monitor: whenever the mesh consumes a pending packet, it must be the oldest expected one.
    always @(negedge clk) begin
        if (!reset && bus.pndng_o && bus.popin_i) begin
            if (sb_q.size() == 0) begin
                chk("pop_unexpected", 64'(bus.data_out_o), 64'hDEAD);
            end else begin
                chk("pop_data", 64'(bus.data_out_o), 64'(sb_q.pop_front()));
            end
        end else if (!reset && !bus.pndng_o) begin
            chk("idle_data", 64'(bus.data_out_o), 64'd0);
        end
    end

    // One clock of stimulus; the model decides acceptance from the rules, then outputs are compared.
    task automatic step(input logic push, input logic bc, input logic [3:0] r, input logic [3:0] c,
                        input logic m, input logic [PS-18:0] pl, input logic pop);
        bit pop_eff;
        bit ok;
        logic [PS-1:0] p;
        bus.push_i     = push;
        bus.bcst_i     = bc;
        bus.dest_row_i = r;
        bus.dest_col_i = c;
        bus.mode_i     = m;
        bus.payload_i  = pl;
        bus.popin_i    = pop;
        p       = build_pkt(bc, r, c, m, pl);
        pop_eff = pop && (model_q.size() > 0);
        ok      = push && (bc || dest_ok(int'(r), int'(c))) && ((model_q.size() < DEP) || pop_eff);
        if (pop_eff) begin
            void'(model_q.pop_front());
            exp_sent = (exp_sent + 1) % 65536;
        end
        if (ok) begin
            model_q.push_back(p);
            sb_q.push_back(p);
        end else if (push && exp_drop < 65535) begin
            exp_drop++;
        end
        @(posedge clk);
        #1;
        chk("count", 64'(bus.count_o), 64'(model_q.size()));
        chk("pndng", 64'(bus.pndng_o), 64'(model_q.size() != 0));
        chk("full", 64'(bus.full_o), 64'(model_q.size() == DEP));
        chk("drop", 64'(bus.drop_cnt_o), 64'(exp_drop));
        chk("sent", 64'(bus.sent_cnt_o), 64'(exp_sent));
    endtask

    task automatic idle(input logic pop);
        step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 15'd0, pop);
    endtask

    task automatic do_reset();
        bus.push_i  = 1'b0;
        bus.popin_i = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_count", 64'(bus.count_o), 64'd0);
        chk("rst_pndng", 64'(bus.pndng_o), 64'd0);
        chk("rst_full", 64'(bus.full_o), 64'd0);
        chk("rst_data", 64'(bus.data_out_o), 64'd0);
        chk("rst_drop", 64'(bus.drop_cnt_o), 64'd0);
        chk("rst_sent", 64'(bus.sent_cnt_o), 64'd0);
        model_q.delete();
        sb_q.delete();
        exp_drop = 0;
        exp_sent = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int guard;
        reset          = 1'b1;
        bus.push_i     = 1'b0;
        bus.bcst_i     = 1'b0;
        bus.dest_row_i = 4'd0;
        bus.dest_col_i = 4'd0;
        bus.mode_i     = 1'b0;
        bus.payload_i  = 15'd0;
        bus.popin_i    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(1'b0);

        // Single packet, then one consumption.
        step(1'b1, 1'b0, 4'd0, 4'd1, 1'b1, 15'h1234, 1'b0);
        chk("single_data", 64'(bus.data_out_o), 64'({8'h00, 4'h0, 4'h1, 1'b1, 15'h1234}));
        idle(1'b1);

        // Interior router destination is rejected; the same coordinates as broadcast are accepted.
        step(1'b1, 1'b0, 4'd2, 4'd2, 1'b0, 15'h0111, 1'b0);
        step(1'b1, 1'b1, 4'd2, 4'd2, 1'b0, 15'h0222, 1'b0);
        chk("bcst_top", 64'(bus.data_out_o[31:24]), 64'hFF);
        idle(1'b1);

        // Fill to capacity, overflow, then push+pop while full.
        for (int i = 0; i < DEP; i++) begin
            step(1'b1, 1'b0, 4'd5, 4'(1 + (i % 4)), i[0], 15'(16'h0100 + i), 1'b0);
        end
        step(1'b1, 1'b0, 4'd0, 4'd2, 1'b0, 15'h7777, 1'b0);
        step(1'b1, 1'b0, 4'd3, 4'd0, 1'b1, 15'h0500, 1'b1);
        guard = 0;
        while (model_q.size() > 0 && guard < 100) begin
            idle(1'b1);
            guard++;
        end

        // Pop while empty has no effect.
        idle(1'b1);
        idle(1'b1);

        // Reset with five packets in flight, then a fresh push lands at the head.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 4'd1, 4'd5, 1'b0, 15'(i + 40), 1'b0);
        end
        do_reset();
        step(1'b1, 1'b0, 4'd4, 4'd0, 1'b0, 15'h2AAA, 1'b0);
        chk("post_rst_head", 64'(bus.data_out_o), 64'(build_pkt(1'b0, 4'd4, 4'd0, 1'b0, 15'h2AAA)));
        idle(1'b1);

        // Sequential payloads against a randomly popping mesh.
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, 4'd0, 4'd3, 1'b0, 15'(i),
                 ($urandom_range(0, 1) == 1) || (model_q.size() == DEP));
        end
        guard = 0;
        while (model_q.size() > 0 && guard < 100) begin
            idle($urandom_range(0, 1) == 1);
            guard++;
        end
        chk("order_sent", 64'(bus.sent_cnt_o), 64'd41);
        chk("order_drop", 64'(bus.drop_cnt_o), 64'd0);

        // Random traffic with mixed valid, invalid and broadcast destinations.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                 4'($urandom_range(0, 6)), 4'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                 15'($urandom), $urandom_range(0, 2) == 0);
        end
        guard = 0;
        while (model_q.size() > 0 && guard < 100) begin
            idle(1'b1);
            guard++;
        end
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
